// File: rtl/dma_sdata_arbiter.sv
// Round-robin two-channel DMA arbiter that fences off the secure stack/data region
// and holds the core in reset after any attempt to touch it.
module dma_sdata_arbiter #(
    parameter logic [15:0] SDATA_BASE    = 16'hA000,
    parameter logic [15:0] SDATA_SIZE    = 16'h1000,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int unsigned TIMEOUT       = 8
) (
    input  logic        clk,
    input  logic        puc_rst,
    input  logic [15:0] pc,
    input  logic        req0,
    input  logic [15:0] addr0,
    input  logic        req1,
    input  logic [15:0] addr1,
    input  logic        dma_ready,
    output logic        gnt0,
    output logic        gnt1,
    output logic        dma_en,
    output logic [15:0] dma_addr,
    output logic        violation,
    output logic [7:0]  viol_cnt
);

    typedef enum logic [2:0] {LOCK, IDLE, GNT0, GNT1, KILL} state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t     state, state_nx;
    logic       last, last_nx;
    logic [7:0] tcnt, tcnt_nx;
    logic       inc_viol;
    logic       sd0, sd1, bad, at_rh;

    // Range check done at 17 bits so BASE+SIZE reaching 64K does not wrap to zero.
    function automatic logic in_sd(input logic [15:0] a);
        logic [16:0] lo;
        logic [16:0] hi;
        lo = {1'b0, SDATA_BASE};
        hi = {1'b0, SDATA_BASE} + {1'b0, SDATA_SIZE};
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

    assign sd0   = in_sd(addr0);
    assign sd1   = in_sd(addr1);
    assign bad   = (req0 && sd0) || (req1 && sd1);
    assign at_rh = (pc == RESET_HANDLER);

    always_comb begin
        state_nx = state;
        last_nx  = last;
        tcnt_nx  = tcnt;
        inc_viol = 1'b0;
        dma_en   = 1'b0;
        dma_addr = 16'h0000;
        case (state)
            LOCK, KILL: begin
                if (at_rh && !bad)
                    state_nx = IDLE;
                else if (at_rh)
                    state_nx = KILL;
            end
            IDLE: begin
                tcnt_nx = 8'd0;
                if (bad) begin
                    state_nx = KILL;
                    inc_viol = 1'b1;
                end else if (req0 && req1)
                    state_nx = last ? GNT0 : GNT1;
                else if (req0)
                    state_nx = GNT0;
                else if (req1)
                    state_nx = GNT1;
            end
            GNT0: begin
                dma_addr = addr0;
                dma_en   = req0 && !sd0;
                tcnt_nx  = tcnt + 8'd1;
                if (bad) begin
                    state_nx = KILL;
                    inc_viol = 1'b1;
                end else if ((dma_ready && dma_en) || !req0 || (tcnt == TMAX)) begin
                    state_nx = IDLE;
                    last_nx  = 1'b0;
                end
            end
            GNT1: begin
                dma_addr = addr1;
                dma_en   = req1 && !sd1;
                tcnt_nx  = tcnt + 8'd1;
                if (bad) begin
                    state_nx = KILL;
                    inc_viol = 1'b1;
                end else if ((dma_ready && dma_en) || !req1 || (tcnt == TMAX)) begin
                    state_nx = IDLE;
                    last_nx  = 1'b1;
                end
            end
            default: state_nx = LOCK;
        endcase
    end

    // Grants and the reset request are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (puc_rst) begin
            state     <= LOCK;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            violation <= 1'b1;
            viol_cnt  <= 8'd0;
            last      <= 1'b1;
            tcnt      <= 8'd0;
        end else begin
            state     <= state_nx;
            gnt0      <= (state_nx == GNT0);
            gnt1      <= (state_nx == GNT1);
            violation <= (state_nx == LOCK) || (state_nx == KILL);
            last      <= last_nx;
            tcnt      <= tcnt_nx;
            if (inc_viol && (viol_cnt != 8'hFF))
                viol_cnt <= viol_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_dma_sdata_arbiter.sv
// Vector/scoreboard bench for dma_sdata_arbiter: each driven vector queues its
// expected outputs, which are popped and compared just after the next rising edge.
module tb_dma_sdata_arbiter;

    localparam int unsigned TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        puc_rst;
    logic [15:0] pc;
    logic        req0, req1, dma_ready;
    logic [15:0] addr0, addr1;
    logic        gnt0, gnt1, dma_en, violation;
    logic [15:0] dma_addr;
    logic [7:0]  viol_cnt;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [15:0] pc;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [3:0]  ex;
        logic [15:0] addr;
        logic [7:0]  cnt;
    } vec_t;

    vec_t  tbl[$];
    string tbl_name[$];
    vec_t  exp_q[$];
    string name_q[$];

    dma_sdata_arbiter #(
        .SDATA_BASE(16'hA000), .SDATA_SIZE(16'h1000),
        .RESET_HANDLER(16'h0000), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .puc_rst(puc_rst), .pc(pc),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .dma_ready(dma_ready),
        .gnt0(gnt0), .gnt1(gnt1), .dma_en(dma_en), .dma_addr(dma_addr),
        .violation(violation), .viol_cnt(viol_cnt)
    );

    always #5 clk = ~clk;

    // ctl = {puc_rst, req0, req1, dma_ready}; ex = {gnt0, gnt1, dma_en, violation}
    function automatic vec_t mk(input logic [3:0] ctl, input logic [15:0] p,
                                input logic [15:0] a0, input logic [15:0] a1,
                                input logic [3:0] ex, input logic [15:0] addr,
                                input logic [7:0] cnt);
        vec_t v;
        v.ctl = ctl; v.pc = p; v.a0 = a0; v.a1 = a1;
        v.ex = ex; v.addr = addr; v.cnt = cnt;
        return v;
    endfunction

    task automatic applyStimulus(input string nm, input vec_t v);
        puc_rst   = v.ctl[3];
        req0      = v.ctl[2];
        req1      = v.ctl[1];
        dma_ready = v.ctl[0];
        pc        = v.pc;
        addr0     = v.a0;
        addr1     = v.a1;
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic cmp(input string nm, input string fld,
                       input logic [15:0] got, input logic [15:0] want);
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s.%s got %h expected %h", nm, fld, got, want);
        end
    endtask

    task automatic checkOutput();
        vec_t  e;
        string nm;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_empty got 0 entries expected 1");
            return;
        end
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        vectors++;
        cmp(nm, "gnt0",      {15'd0, gnt0},      {15'd0, e.ex[3]});
        cmp(nm, "gnt1",      {15'd0, gnt1},      {15'd0, e.ex[2]});
        cmp(nm, "dma_en",    {15'd0, dma_en},    {15'd0, e.ex[1]});
        cmp(nm, "violation", {15'd0, violation}, {15'd0, e.ex[0]});
        cmp(nm, "dma_addr",  dma_addr,           e.addr);
        cmp(nm, "viol_cnt",  {8'd0, viol_cnt},   {8'd0, e.cnt});
    endtask

    task automatic step(input string nm, input vec_t v);
        applyStimulus(nm, v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   cnt_exp;
        logic [3:0] ctl;

        puc_rst = 1'b1; pc = 16'h1234; req0 = 1'b0; req1 = 1'b0;
        addr0 = 16'h0000; addr1 = 16'h0000; dma_ready = 1'b0;

        tbl.push_back(mk(4'b1000, 16'h1234, 16'h0000, 16'h0000, 4'b0001, 16'h0000, 8'd0)); tbl_name.push_back("reset");
        tbl.push_back(mk(4'b0000, 16'h1234, 16'h0000, 16'h0000, 4'b0001, 16'h0000, 8'd0)); tbl_name.push_back("lock_hold");
        tbl.push_back(mk(4'b0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 8'd0)); tbl_name.push_back("lock_exit");
        tbl.push_back(mk(4'b0110, 16'h1234, 16'h0200, 16'h0400, 4'b1010, 16'h0200, 8'd0)); tbl_name.push_back("rr_gnt0");
        tbl.push_back(mk(4'b0110, 16'h1234, 16'h0200, 16'h0400, 4'b1010, 16'h0200, 8'd0)); tbl_name.push_back("rr_gnt0_hold");
        tbl.push_back(mk(4'b0111, 16'h1234, 16'h0200, 16'h0400, 4'b0000, 16'h0000, 8'd0)); tbl_name.push_back("rr_gnt0_done");
        tbl.push_back(mk(4'b0110, 16'h1234, 16'h0200, 16'h0400, 4'b0110, 16'h0400, 8'd0)); tbl_name.push_back("rr_gnt1");
        tbl.push_back(mk(4'b0110, 16'h1234, 16'h0200, 16'h0400, 4'b0110, 16'h0400, 8'd0)); tbl_name.push_back("rr_gnt1_hold");
        tbl.push_back(mk(4'b0111, 16'h1234, 16'h0200, 16'h0400, 4'b0000, 16'h0000, 8'd0)); tbl_name.push_back("rr_gnt1_done");
        tbl.push_back(mk(4'b0110, 16'h1234, 16'h0200, 16'h0400, 4'b1010, 16'h0200, 8'd0)); tbl_name.push_back("rr_gnt0_again");
        tbl.push_back(mk(4'b0110, 16'h1234, 16'h0200, 16'h0400, 4'b1010, 16'h0200, 8'd0)); tbl_name.push_back("rr_gnt0_again_hold");
        tbl.push_back(mk(4'b0111, 16'h1234, 16'h0200, 16'h0400, 4'b0000, 16'h0000, 8'd0)); tbl_name.push_back("rr_gnt0_again_done");
        tbl.push_back(mk(4'b0100, 16'h1234, 16'h9FFF, 16'h0000, 4'b1010, 16'h9FFF, 8'd0)); tbl_name.push_back("below_sdata");
        tbl.push_back(mk(4'b0101, 16'h1234, 16'h9FFF, 16'h0000, 4'b0000, 16'h0000, 8'd0)); tbl_name.push_back("below_done");
        tbl.push_back(mk(4'b0100, 16'h1234, 16'hA000, 16'h0000, 4'b0001, 16'h0000, 8'd1)); tbl_name.push_back("sdata_base");
        tbl.push_back(mk(4'b0000, 16'h0000, 16'hA000, 16'h0000, 4'b0000, 16'h0000, 8'd1)); tbl_name.push_back("kill_exit1");
        tbl.push_back(mk(4'b0100, 16'h1234, 16'hAFFF, 16'h0000, 4'b0001, 16'h0000, 8'd2)); tbl_name.push_back("sdata_last");
        tbl.push_back(mk(4'b0000, 16'h0000, 16'hAFFF, 16'h0000, 4'b0000, 16'h0000, 8'd2)); tbl_name.push_back("kill_exit2");
        tbl.push_back(mk(4'b0100, 16'h1234, 16'hB000, 16'h0000, 4'b1010, 16'hB000, 8'd2)); tbl_name.push_back("above_sdata");
        tbl.push_back(mk(4'b0101, 16'h1234, 16'hB000, 16'h0000, 4'b0000, 16'h0000, 8'd2)); tbl_name.push_back("above_done");
        tbl.push_back(mk(4'b0010, 16'h1234, 16'h0000, 16'h0400, 4'b0110, 16'h0400, 8'd2)); tbl_name.push_back("gnt1_single");

        for (int i = 0; i < tbl.size(); i++)
            step(tbl_name[i], tbl[i]);

        // Address turns illegal while granted: enable must drop before any edge.
        applyStimulus("mid_illegal_comb", mk(4'b0010, 16'h1234, 16'h0000, 16'hA010, 4'b0100, 16'hA010, 8'd2));
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        step("mid_illegal_kill", mk(4'b0010, 16'h1234, 16'h0000, 16'hA010, 4'b0001, 16'h0000, 8'd3));
        step("kill_hold_bad",    mk(4'b0010, 16'h0000, 16'h0000, 16'hA010, 4'b0001, 16'h0000, 8'd3));
        step("kill_release",     mk(4'b0000, 16'h0000, 16'h0000, 16'hA010, 4'b0000, 16'h0000, 8'd3));

        for (int i = 0; i < int'(TIMEOUT); i++) begin
            ctl = (i == 0) ? 4'b0100 : 4'b0110;
            step("timeout_gnt0", mk(ctl, 16'h1234, 16'h0300, 16'h0500, 4'b1010, 16'h0300, 8'd3));
        end
        step("timeout_release",   mk(4'b0110, 16'h1234, 16'h0300, 16'h0500, 4'b0000, 16'h0000, 8'd3));
        step("timeout_next_gnt1", mk(4'b0110, 16'h1234, 16'h0300, 16'h0500, 4'b0110, 16'h0500, 8'd3));
        step("gnt1_drop",         mk(4'b0001, 16'h1234, 16'h0300, 16'h0500, 4'b0000, 16'h0000, 8'd3));

        cnt_exp = 3;
        for (int i = 0; i < 300; i++) begin
            cnt_exp = (cnt_exp < 255) ? cnt_exp + 1 : 255;
            step("sat_kill", mk(4'b0100, 16'h1234, 16'hA000, 16'h0000, 4'b0001, 16'h0000, 8'(cnt_exp)));
            step("sat_exit", mk(4'b0000, 16'h0000, 16'hA000, 16'h0000, 4'b0000, 16'h0000, 8'(cnt_exp)));
        end

        step("pre_reset_gnt0",   mk(4'b0100, 16'h1234, 16'h0200, 16'h0000, 4'b1010, 16'h0200, 8'hFF));
        step("reset_mid_grant",  mk(4'b1100, 16'h1234, 16'h0200, 16'h0000, 4'b0001, 16'h0000, 8'd0));
        step("lock_after_reset", mk(4'b0100, 16'h1234, 16'h0200, 16'h0000, 4'b0001, 16'h0000, 8'd0));
        step("lock_exit2",       mk(4'b0000, 16'h0000, 16'h0200, 16'h0000, 4'b0000, 16'h0000, 8'd0));
        step("rr_first_after_reset", mk(4'b0110, 16'h1234, 16'h0200, 16'h0400, 4'b1010, 16'h0200, 8'd0));

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
